// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dino_pkg
//  Description : Shared definitions for the dino runner game. Holds the
//                game-state encoding and the default ground line so the
//                sequencer and the VGA renderer agree on both.
//  Ports       : (package - no ports)
//  Revision    : 1.0 - initial release
// ============================================================================
package dino_pkg;

    // Game-state encoding, visible on the sequencer's state output
    localparam logic [1:0] ST_IDLE_ENC = 2'b00;
    localparam logic [1:0] ST_RUN_ENC  = 2'b01;
    localparam logic [1:0] ST_JUMP_ENC = 2'b10;
    localparam logic [1:0] ST_OVER_ENC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE_ENC,
        S_RUN  = ST_RUN_ENC,
        S_JUMP = ST_JUMP_ENC,
        S_OVER = ST_OVER_ENC
    } state_t;

    // Bottom y-coordinate of the dino when standing on the ground
    localparam int GROUND_Y_DEFAULT = 400;

endpackage : dino_pkg
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Conditions a raw, bouncing push button. Two-flop
//                synchronizer, stability counter and a registered one-cycle
//                pulse on the debounced rising edge (release is silent).
//  Ports       : clk       - system clock
//                reset     - synchronous, active-low reset
//                i_button  - raw asynchronous button level (high = pressed)
//                o_press   - one-cycle pulse per accepted press
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_button,
    output logic o_press
);

    // Counter only has to reach DEBOUNCE_CYCLES-1 before the level flips
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;

            // The level flips on the DEBOUNCE_CYCLES-th consecutive sample
            // that disagrees with it; a single agreeing sample restarts.
            if (r_sync2 != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end

            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
        end
    end

    assign o_press = r_press;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/dino_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dino_game_sequencer
//  Description : Game-flow controller for the dino runner. Sequences
//                IDLE -> RUN <-> JUMP -> OVER -> IDLE, generates the dino's
//                vertical position once per frame and drives the enable and
//                clear strobes of the BCD score counter.
//  Ports       : clk                - 100 MHz system clock
//                reset              - synchronous, active-low reset
//                button_press       - raw bouncing push button
//                frame_tick         - one-cycle pulse per displayed frame
//                collision_detected - dino overlaps an obstacle (level)
//                dino_y             - dino bottom y-coordinate
//                jumping            - high while in JUMP
//                score_en           - one-cycle pulse per scored frame
//                score_clr          - one-cycle pulse clearing the score
//                game_over          - high while in OVER
//                state              - current state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
module dino_game_sequencer
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GROUND_Y        = GROUND_Y_DEFAULT,
    parameter int JUMP_HEIGHT     = 120,
    parameter int JUMP_STEP       = 8,
    parameter int Y_W             = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           button_press,
    input  logic           frame_tick,
    input  logic           collision_detected,
    output logic [Y_W-1:0] dino_y,
    output logic           jumping,
    output logic           score_en,
    output logic           score_clr,
    output logic           game_over,
    output logic [1:0]     state
);

    localparam logic [Y_W-1:0] c_ground = Y_W'(GROUND_Y);
    localparam logic [Y_W-1:0] c_height = Y_W'(JUMP_HEIGHT);
    localparam logic [Y_W-1:0] c_step   = Y_W'(JUMP_STEP);

    logic w_press;

    state_t         r_state;
    logic [Y_W-1:0] r_h;
    logic           r_up;
    logic [Y_W-1:0] r_dino_y;
    logic           r_jumping;
    logic           r_score_en;
    logic           r_score_clr;
    logic           r_game_over;

    logic [Y_W:0]   w_sum_up;
    logic [Y_W-1:0] w_h_up;
    logic [Y_W-1:0] w_h_dn;
    logic [Y_W-1:0] w_y_up;
    logic [Y_W-1:0] w_y_dn;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .i_button (button_press),
        .o_press  (w_press)
    );

    // Candidate jump offsets for the rising and falling phases. The sum is
    // one bit wider so the clamp to JUMP_HEIGHT cannot be fooled by wrap.
    assign w_sum_up = {1'b0, r_h} + {1'b0, c_step};
    assign w_h_up   = (w_sum_up >= {1'b0, c_height}) ? c_height : w_sum_up[Y_W-1:0];
    assign w_h_dn   = (r_h <= c_step) ? '0 : (r_h - c_step);
    assign w_y_up   = c_ground - w_h_up;
    assign w_y_dn   = c_ground - w_h_dn;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_h         <= '0;
            r_up        <= 1'b0;
            r_dino_y    <= c_ground;
            r_jumping   <= 1'b0;
            r_score_en  <= 1'b0;
            r_score_clr <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_score_en  <= 1'b0;
            r_score_clr <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        r_state     <= S_RUN;
                        r_score_clr <= 1'b1;
                        r_h         <= '0;
                        r_up        <= 1'b0;
                        r_dino_y    <= c_ground;
                    end
                end

                S_RUN: begin
                    // Collision wins over any press or tick in the same cycle
                    if (collision_detected) begin
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        if (frame_tick) begin
                            r_score_en <= 1'b1;
                        end
                        // Entering JUMP leaves h untouched; the first height
                        // change waits for the next tick.
                        if (w_press) begin
                            r_state   <= S_JUMP;
                            r_up      <= 1'b1;
                            r_jumping <= 1'b1;
                        end
                    end
                end

                S_JUMP: begin
                    if (collision_detected) begin
                        // dino_y freezes where the hit happened
                        r_state     <= S_OVER;
                        r_game_over <= 1'b1;
                        r_jumping   <= 1'b0;
                    end else if (frame_tick) begin
                        r_score_en <= 1'b1;
                        if (r_up) begin
                            r_h      <= w_h_up;
                            r_dino_y <= w_y_up;
                            if (w_h_up == c_height) begin
                                r_up <= 1'b0;
                            end
                        end else begin
                            r_h      <= w_h_dn;
                            r_dino_y <= w_y_dn;
                            // Landing returns to RUN on the same update
                            if (w_h_dn == '0) begin
                                r_state   <= S_RUN;
                                r_jumping <= 1'b0;
                            end
                        end
                    end
                end

                S_OVER: begin
                    if (w_press) begin
                        r_state     <= S_IDLE;
                        r_game_over <= 1'b0;
                        r_h         <= '0;
                        r_up        <= 1'b0;
                        r_dino_y    <= c_ground;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dino_y    = r_dino_y;
    assign jumping   = r_jumping;
    assign score_en  = r_score_en;
    assign score_clr = r_score_clr;
    assign game_over = r_game_over;
    assign state     = r_state;

endmodule : dino_game_sequencer
`default_nettype wire

// File: tb/tb_dino_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dino_game_sequencer
//  Description : Self-checking bench for dino_game_sequencer. Stimulus pushes
//                hand-computed expected output snapshots, tagged with the
//                clock edge at which they must appear, into a scoreboard
//                queue; a monitor pops and compares them after each edge.
//  Ports       : (none)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dino_game_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       button_press;
    logic       frame_tick;
    logic       collision_detected;
    logic [9:0] dino_y;
    logic       jumping;
    logic       score_en;
    logic       score_clr;
    logic       game_over;
    logic [1:0] state;

    always #5 clk = ~clk;

    dino_game_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .GROUND_Y        (400),
        .JUMP_HEIGHT     (24),
        .JUMP_STEP       (8),
        .Y_W             (10)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .button_press       (button_press),
        .frame_tick         (frame_tick),
        .collision_detected (collision_detected),
        .dino_y             (dino_y),
        .jumping            (jumping),
        .score_en           (score_en),
        .score_clr          (score_clr),
        .game_over          (game_over),
        .state              (state)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] st;
        logic [9:0] y;
        logic       jmp;
        logic       sen;
        logic       sclr;
        logic       go;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   sample_idx = 0;
    int   checks     = 0;
    int   errors     = 0;

    // Expect the given snapshot k rising edges from now
    task automatic sb_push(input int k, input string nm, input logic [1:0] st,
                           input int y, input logic jmp, input logic sen,
                           input logic sclr, input logic go);
        exp_t e;
        e.cyc  = sample_idx + k;
        e.name = nm;
        e.st   = st;
        e.y    = 10'(y);
        e.jmp  = jmp;
        e.sen  = sen;
        e.sclr = sclr;
        e.go   = go;
        sb.push_back(e);
    endtask

    // Monitor: sample 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        sample_idx++;
        while (sb.size() > 0 && sb[0].cyc <= sample_idx) begin
            m_e = sb.pop_front();
            checks++;
            if (m_e.cyc != sample_idx || state !== m_e.st || dino_y !== m_e.y ||
                jumping !== m_e.jmp || score_en !== m_e.sen ||
                score_clr !== m_e.sclr || game_over !== m_e.go) begin
                errors++;
                $display("FAIL %s @edge%0d: got st=%0d y=%0d jmp=%b sen=%b clr=%b go=%b, want st=%0d y=%0d jmp=%b sen=%b clr=%b go=%b",
                         m_e.name, sample_idx, state, dino_y, jumping, score_en,
                         score_clr, game_over, m_e.st, m_e.y, m_e.jmp, m_e.sen,
                         m_e.sclr, m_e.go);
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: the state reacts 8 edges after the button goes high
    task automatic press_btn();
        button_press = 1'b1;
        cyc_wait(10);
        button_press = 1'b0;
        cyc_wait(8);
    endtask

    // One frame tick, then check the strobe dropped and y held
    task automatic tick_exp(input string nm, input logic [1:0] st, input int y,
                            input logic jmp);
        frame_tick = 1'b1;
        sb_push(1, nm, st, y, jmp, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        frame_tick = 1'b0;
        sb_push(1, {nm, "_hold"}, st, y, jmp, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset              = 1'b0;
        button_press       = 1'b0;
        frame_tick         = 1'b0;
        collision_detected = 1'b0;
        cyc_wait(2);
        sb_push(1, "reset", 2'd0, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // IDLE ignores tick and collision
        frame_tick         = 1'b1;
        collision_detected = 1'b1;
        sb_push(1, "idle_tick_col", 2'd0, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        frame_tick         = 1'b0;
        collision_detected = 1'b0;

        // Short bounces never reach the stability threshold
        repeat (3) begin
            button_press = 1'b1;
            cyc_wait(2);
            button_press = 1'b0;
            cyc_wait(2);
        end
        cyc_wait(4);
        sb_push(1, "bounce_idle", 2'd0, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Stable press: RUN at spec edge 7 (8th rising edge), clear once
        sb_push(7, "deb_pre", 2'd0, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_push(8, "deb_run", 2'd1, 400, 1'b0, 1'b0, 1'b1, 1'b0);
        sb_push(9, "deb_clr_once", 2'd1, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        press_btn();
        sb_push(1, "release_quiet", 2'd1, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Full jump arc
        sb_push(7, "jmp_pre", 2'd1, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_push(8, "jmp_start", 2'd2, 400, 1'b1, 1'b0, 1'b0, 1'b0);
        press_btn();
        tick_exp("j1", 2'd2, 392, 1'b1);
        tick_exp("j2", 2'd2, 384, 1'b1);
        tick_exp("j3", 2'd2, 376, 1'b1);
        tick_exp("j4", 2'd2, 384, 1'b1);
        tick_exp("j5", 2'd2, 392, 1'b1);
        tick_exp("j6", 2'd1, 400, 1'b0);

        // Collision has priority over a simultaneous tick
        sb_push(8, "jmp2_start", 2'd2, 400, 1'b1, 1'b0, 1'b0, 1'b0);
        press_btn();
        tick_exp("k1", 2'd2, 392, 1'b1);
        tick_exp("k2", 2'd2, 384, 1'b1);
        frame_tick         = 1'b1;
        collision_detected = 1'b1;
        sb_push(1, "col_pri", 2'd3, 384, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        frame_tick         = 1'b0;
        collision_detected = 1'b0;
        sb_push(1, "over_hold", 2'd3, 384, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        frame_tick = 1'b1;
        sb_push(1, "over_tick", 2'd3, 384, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        frame_tick = 1'b0;

        // Restart: OVER -> IDLE, then IDLE -> RUN
        sb_push(7, "over_pre", 2'd3, 384, 1'b0, 1'b0, 1'b0, 1'b1);
        sb_push(8, "restart_idle", 2'd0, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        press_btn();
        sb_push(8, "newgame", 2'd1, 400, 1'b0, 1'b0, 1'b1, 1'b0);
        sb_push(9, "newgame_clr1", 2'd1, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        press_btn();

        // Reset in the middle of a jump
        sb_push(8, "jmp3_start", 2'd2, 400, 1'b1, 1'b0, 1'b0, 1'b0);
        press_btn();
        tick_exp("m1", 2'd2, 392, 1'b1);
        tick_exp("m2", 2'd2, 384, 1'b1);
        tick_exp("m3", 2'd2, 376, 1'b1);
        reset = 1'b0;
        sb_push(1, "mid_reset", 2'd0, 400, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        sb_push(8, "post_run", 2'd1, 400, 1'b0, 1'b0, 1'b1, 1'b0);
        press_btn();
        sb_push(8, "post_jump", 2'd2, 400, 1'b1, 1'b0, 1'b0, 1'b0);
        press_btn();
        tick_exp("post_j1", 2'd2, 392, 1'b1);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dino_game_sequencer
`default_nettype wire
